// File: rtl/seg_ctrl_pkg.sv
// Shared definitions for the segment controller: frame opcodes, frame length
// and the 7-segment hex font (gfedcba, active high).
package seg_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RAW   = 2'b00,
    OP_HEX   = 2'b01,
    OP_BLINK = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam int unsigned FRAME_BITS = 16;

  // Index 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit value to 7-segment pattern (gfedcba) lookup.
module seg_hex_decoder
  import seg_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_FONT[nibble];
  end

endmodule

// File: rtl/spi_segment_rx.sv
// SPI mode-0 slave that receives 16-bit command frames, holds the segment
// pattern, offers read-back on MISO and an optional divider-timed blink.
module spi_segment_rx
  import seg_ctrl_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic [7:0] seg_o,
  output logic       frame_valid_o,
  output logic       frame_err_o
);

  logic [2:0]  sclk_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic [2:0]  sync_vld;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, cs_low, mosi_s;

  logic [15:0] shift;
  logic [4:0]  bit_cnt;
  logic        armed;
  logic [7:0]  rb;
  logic [7:0]  seg_reg;
  logic        blink_en;
  logic        phase;
  logic [23:0] blink_cnt;

  logic [7:0]  cmd, data;
  op_e         op;
  logic [6:0]  font;
  logic        unused_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      sync_vld <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], sclk_i};
      cs_q     <= {cs_q[1:0], cs_n_i};
      mosi_q   <= {mosi_q[0], mosi_i};
      sync_vld <= {sync_vld[1:0], 1'b1};
    end
  end

  // A CS fall only counts once both compared samples came from the pin, so a
  // frame already in progress at reset release is never armed.
  assign cs_low    = ~cs_q[1];
  assign cs_fall   = ~cs_q[1] & cs_q[2] & sync_vld[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign mosi_s    = mosi_q[1];

  assign cmd        = shift[15:8];
  assign data       = shift[7:0];
  assign op         = op_e'(cmd[7:6]);
  assign unused_cmd = ^cmd[5:0];

  seg_hex_decoder u_hex (
    .nibble (data[3:0]),
    .seg    (font)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift         <= '0;
      bit_cnt       <= '0;
      armed         <= 1'b0;
      rb            <= '0;
      seg_reg       <= '0;
      blink_en      <= 1'b0;
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
      if (cs_fall) begin
        shift   <= '0;
        bit_cnt <= '0;
        armed   <= 1'b1;
        rb      <= seg_reg;
      end else if (cs_rise) begin
        if (armed) begin
          armed <= 1'b0;
          if (bit_cnt == 5'(FRAME_BITS) && op != OP_RSVD) begin
            case (op)
              OP_RAW:   seg_reg  <= data;
              OP_HEX:   seg_reg  <= {data[4], font};
              OP_BLINK: blink_en <= data[0];
              default:  ;
            endcase
            frame_valid_o <= 1'b1;
          end else begin
            frame_err_o <= 1'b1;
          end
        end
      end else if (cs_low) begin
        if (sclk_rise) begin
          shift <= {shift[14:0], mosi_s};
          if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
        end
        if (sclk_fall) rb <= {rb[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == MAX_COUNT - 24'd1) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  assign miso_o = cs_low & rb[7];
  assign seg_o  = (blink_en & phase) ? 8'h00 : seg_reg;

endmodule

// File: tb/tb_spi_segment_rx.sv
// Directed bench for spi_segment_rx: frame decode, errors, blink, read-back,
// and reset in the middle of a frame.
module tb_spi_segment_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso_o;
  logic [7:0] seg_o;
  logic       frame_valid_o;
  logic       frame_err_o;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  spi_segment_rx #(.MAX_COUNT(24'd4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sclk_i        (sclk),
    .cs_n_i        (cs_n),
    .mosi_i        (mosi),
    .miso_o        (miso_o),
    .seg_o         (seg_o),
    .frame_valid_o (frame_valid_o),
    .frame_err_o   (frame_err_o)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a pulse wider than one cycle shows up as >1.
  always @(negedge clk) begin
    if (frame_valid_o) valid_cnt++;
    if (frame_err_o)   err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    tick(6);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, output logic [31:0] miso_bits);
    miso_bits = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      tick(2);
      miso_bits = {miso_bits[30:0], miso_o};
      sclk = 1'b1;
      tick(6);
      sclk = 1'b0;
      tick(4);
    end
  endtask

  task automatic cs_end();
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic frame(input logic [31:0] w, input int n, output logic [31:0] miso_bits);
    valid_cnt = 0;
    err_cnt = 0;
    cs_begin();
    send_bits(w, n, miso_bits);
    cs_end();
  endtask

  initial begin
    logic [31:0] mb;
    logic [7:0]  v;
    logic [7:0]  prev;
    logic        found;

    tick(3);
    check_eq("rst_seg", seg_o, 8'h00);
    check_eq("rst_miso", miso_o, 1'b0);
    check_eq("rst_valid", frame_valid_o, 1'b0);
    check_eq("rst_err", frame_err_o, 1'b0);
    rst_n = 1'b1;
    tick(4);

    frame(32'h00A5, 16, mb);
    check_eq("raw_seg", seg_o, 8'hA5);
    check_eq("raw_valid", valid_cnt, 1);
    check_eq("raw_err", err_cnt, 0);

    frame(32'h401B, 16, mb);
    check_eq("hex_seg", seg_o, 8'hFC);
    check_eq("hex_valid", valid_cnt, 1);

    frame(32'h0012, 15, mb);
    check_eq("short_err", err_cnt, 1);
    check_eq("short_valid", valid_cnt, 0);
    check_eq("short_seg", seg_o, 8'hFC);

    frame(32'h000FF, 17, mb);
    check_eq("long_err", err_cnt, 1);
    check_eq("long_seg", seg_o, 8'hFC);

    frame(32'hC0FF, 16, mb);
    check_eq("rsvd_err", err_cnt, 1);
    check_eq("rsvd_valid", valid_cnt, 0);
    check_eq("rsvd_seg", seg_o, 8'hFC);

    frame(32'h003F, 16, mb);
    check_eq("raw3f_seg", seg_o, 8'h3F);

    frame(32'h8001, 16, mb);
    check_eq("blink_on_valid", valid_cnt, 1);
    prev = seg_o;
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (seg_o != prev) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("blink_edge", found, 1'b1);
    for (int r = 0; r < 3; r++) begin
      v = seg_o;
      check_eq("blink_level", (v == 8'h00 || v == 8'h3F), 1'b1);
      for (int j = 0; j < 3; j++) begin
        tick(1);
        check_eq("blink_hold", seg_o, v);
      end
      tick(1);
      check_eq("blink_toggle", seg_o, (v == 8'h3F) ? 8'h00 : 8'h3F);
    end

    frame(32'h8000, 16, mb);
    check_eq("blink_off_valid", valid_cnt, 1);
    for (int k = 0; k < 10; k++) begin
      check_eq("blink_off_seg", seg_o, 8'h3F);
      tick(1);
    end

    frame(32'h005A, 16, mb);
    check_eq("rb_seg", seg_o, 8'h5A);
    frame(32'h005A, 16, mb);
    check_eq("rb_miso_bits", mb[15:0], 16'h5A00);
    check_eq("rb_miso_idle", miso_o, 1'b0);

    cs_begin();
    send_bits(32'h00, 8, mb);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    valid_cnt = 0;
    err_cnt = 0;
    send_bits(32'hFF, 8, mb);
    cs_end();
    check_eq("midrst_valid", valid_cnt, 0);
    check_eq("midrst_err", err_cnt, 0);
    check_eq("midrst_seg", seg_o, 8'h00);

    frame(32'h0081, 16, mb);
    check_eq("post_rst_seg", seg_o, 8'h81);
    check_eq("post_rst_valid", valid_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
